// File: rtl/regfile_param.sv
// Parameterised register file: two write ports (port 1 has priority), two
// combinational read ports with same-cycle write forwarding, one optional
// I/O-mapped register, and a per-register pending (scoreboard) bit.
// Register 0 is hard-wired to zero and can never be written or marked pending.
module regfile_param #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int IOREG  = 30,
  parameter int IOMODE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  logic [DW-1:0] wd0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  logic [DW-1:0] wd1,
  input  logic [DW-1:0] iodin,
  output logic [DW-1:0] ioout,
  input  logic          iss,
  input  logic [AW-1:0] iss_a,
  output logic          busy1,
  output logic          busy2,
  output logic          busy_any
);

  localparam int N = 1 << AW;
  localparam logic [AW-1:0] IO_A = AW'(IOREG);

  logic [DW-1:0] regs_q [N];
  logic [DW-1:0] regs_d [N];
  logic [N-1:0]  pend_q;
  logic [N-1:0]  pend_d;

  logic          eff0;
  logic          eff1;
  logic [DW-1:0] sv0;
  logic [DW-1:0] sv1;

  // A write is effective only when enabled and not aimed at register 0.
  // The stored value is iodin when the target is the I/O register in I/O mode.
  assign eff0 = we0 && (wa0 != '0);
  assign eff1 = we1 && (wa1 != '0);
  assign sv0  = ((IOMODE == 1) && (wa0 == IO_A)) ? iodin : wd0;
  assign sv1  = ((IOMODE == 1) && (wa1 == IO_A)) ? iodin : wd1;

  // Read ports: register 0 reads zero, otherwise forward port 1, then port 0,
  // then the stored contents. Forwarding stays active during reset.
  always_comb begin
    rd1 = regs_q[ra1];
    if (ra1 == '0)                     rd1 = '0;
    else if (eff1 && (wa1 == ra1))     rd1 = sv1;
    else if (eff0 && (wa0 == ra1))     rd1 = sv0;

    rd2 = regs_q[ra2];
    if (ra2 == '0)                     rd2 = '0;
    else if (eff1 && (wa1 == ra2))     rd2 = sv1;
    else if (eff0 && (wa0 == ra2))     rd2 = sv0;
  end

  // I/O register view, forwarded the same way as the read ports.
  always_comb begin
    ioout = regs_q[IO_A];
    if (eff1 && (wa1 == IO_A))         ioout = sv1;
    else if (eff0 && (wa0 == IO_A))    ioout = sv0;
  end

  // Busy flags show the registered pending bit only; no same-cycle forwarding.
  assign busy1    = pend_q[ra1];
  assign busy2    = pend_q[ra2];
  assign busy_any = |pend_q;

  // Next register contents: port 0 first so port 1 overrides on a collision.
  always_comb begin
    for (int i = 0; i < N; i++) regs_d[i] = regs_q[i];
    if (eff0) regs_d[wa0] = sv0;
    if (eff1) regs_d[wa1] = sv1;
  end

  // Next pending bits: writes clear, then an issue sets (set wins on a tie).
  always_comb begin
    pend_d = pend_q;
    if (eff0) pend_d[wa0] = 1'b0;
    if (eff1) pend_d[wa1] = 1'b0;
    if (iss && (iss_a != '0)) pend_d[iss_a] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // State update; reset discards any simultaneous write or issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) regs_q[i] <= '0;
      pend_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) regs_q[i] <= regs_d[i];
      pend_q <= pend_d;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: one instance in I/O mode, one with IOREG ordinary,
// both driven by the same inputs and checked against an array-based model.
module tb_regfile_param;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int IOREG = 30;

  // ---------------- clock ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT inputs/outputs ----------------
  logic          rst = 1'b1;
  logic [AW-1:0] ra1 = '0, ra2 = '0, wa0 = '0, wa1 = '0, iss_a = '0;
  logic          we0 = 1'b0, we1 = 1'b0, iss = 1'b0;
  logic [DW-1:0] wd0 = '0, wd1 = '0, iodin = '0;

  logic [DW-1:0] rd1_a, rd2_a, ioout_a, rd1_b, rd2_b, ioout_b;
  logic          busy1_a, busy2_a, busy_any_a, busy1_b, busy2_b, busy_any_b;

  regfile_param #(.DW(DW), .AW(AW), .IOREG(IOREG), .IOMODE(1)) u_dut_io (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iodin(iodin), .ioout(ioout_a), .iss(iss), .iss_a(iss_a),
    .busy1(busy1_a), .busy2(busy2_a), .busy_any(busy_any_a)
  );

  regfile_param #(.DW(DW), .AW(AW), .IOREG(IOREG), .IOMODE(0)) u_dut_plain (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iodin(iodin), .ioout(ioout_b), .iss(iss), .iss_a(iss_a),
    .busy1(busy1_b), .busy2(busy2_b), .busy_any(busy_any_b)
  );

  // ---------------- reference model ----------------
  // m_reg[mode][addr]: mode 1 = I/O instance, mode 0 = plain instance.
  logic [DW-1:0] m_reg [2][32];
  bit            m_pend [32];

  int n_total  = 0;
  int n_passed = 0;

  function automatic logic [DW-1:0] stored(int mode, int a, logic [DW-1:0] d);
    return (mode == 1 && a == IOREG) ? iodin : d;
  endfunction

  // Value a reader of address a must see right now (forwarding included).
  function automatic logic [DW-1:0] exp_view(int mode, int a);
    if (a == 0) return '0;
    if (we1 && int'(wa1) == a) return stored(mode, a, wd1);
    if (we0 && int'(wa0) == a) return stored(mode, a, wd0);
    return m_reg[mode][a];
  endfunction

  function automatic bit exp_any();
    for (int i = 1; i < 32; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Apply one rising edge to the model.
  task automatic model_edge();
    if (rst) begin
      for (int m = 0; m < 2; m++) for (int i = 0; i < 32; i++) m_reg[m][i] = '0;
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    end else begin
      logic [DW-1:0] nxt [2][32];
      bit            np [32];
      nxt = m_reg;
      np  = m_pend;
      for (int m = 0; m < 2; m++) begin
        if (we0 && wa0 != 0) nxt[m][wa0] = stored(m, int'(wa0), wd0);
        if (we1 && wa1 != 0) nxt[m][wa1] = stored(m, int'(wa1), wd1);
      end
      if (we0 && wa0 != 0) np[wa0] = 1'b0;
      if (we1 && wa1 != 0) np[wa1] = 1'b0;
      if (iss && iss_a != 0) np[iss_a] = 1'b1;
      m_reg  = nxt;
      m_pend = np;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    chk("rd1",      rd1_a,            exp_view(1, int'(ra1)));
    chk("rd2",      rd2_a,            exp_view(1, int'(ra2)));
    chk("ioout",    ioout_a,          exp_view(1, IOREG));
    chk("busy1",    DW'(busy1_a),     DW'(m_pend[ra1]));
    chk("busy2",    DW'(busy2_a),     DW'(m_pend[ra2]));
    chk("busy_any", DW'(busy_any_a),  DW'(exp_any()));
    chk("p_rd1",    rd1_b,            exp_view(0, int'(ra1)));
    chk("p_rd2",    rd2_b,            exp_view(0, int'(ra2)));
    chk("p_ioout",  ioout_b,          exp_view(0, IOREG));
    chk("p_busyany", DW'(busy_any_b), DW'(exp_any()));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; outputs are sampled 2
  // units later, well before the next edge.
  task automatic settle();
    #2;
    check_outputs();
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; we0 = 1'b0; we1 = 1'b0; iss = 1'b0;
  endtask

  task automatic wr0(int a, logic [DW-1:0] d);
    we0 = 1'b1; wa0 = AW'(a); wd0 = d;
  endtask

  task automatic wr1(int a, logic [DW-1:0] d);
    we1 = 1'b1; wa1 = AW'(a); wd1 = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // First reset: model and DUT state become defined here.
    rst = 1'b1;
    clock_edge();
    idle();
    ra1 = 5'd0; ra2 = 5'd1;
    settle();
    chk("reset_rd2",  rd2_a,           32'h0);
    chk("reset_busy", DW'(busy_any_a), 32'h0);
    clock_edge();

    // Dual write to distinct registers, then read back.
    wr0(1, 32'h0000_000B); wr1(2, 32'h0000_0011);
    settle(); clock_edge(); idle();
    ra1 = 5'd1; ra2 = 5'd2;
    settle();
    chk("r1_val", rd1_a, 32'h0000_000B);
    chk("r2_val", rd2_a, 32'h0000_0011);
    clock_edge();

    // Collision on r5: port 1 wins, forwarded in the same cycle.
    wr0(5, 32'hAAAA_0000); wr1(5, 32'h5555_FFFF); ra1 = 5'd5;
    settle();
    chk("collide_fwd", rd1_a, 32'h5555_FFFF);
    clock_edge(); idle();
    settle();
    chk("collide_store", rd1_a, 32'h5555_FFFF);
    clock_edge();

    // I/O register write: iodin captured in I/O mode, wd0 otherwise.
    wr0(IOREG, 32'h0000_0001); iodin = 32'hDEAD_BEEF;
    settle();
    chk("io_fwd",       ioout_a, 32'hDEAD_BEEF);
    chk("io_plain_fwd", ioout_b, 32'h0000_0001);
    clock_edge(); idle(); iodin = 32'h1357_9BDF;
    settle();
    chk("io_store",       ioout_a, 32'hDEAD_BEEF);
    chk("io_plain_store", ioout_b, 32'h0000_0001);
    clock_edge();

    // Register 0 ignores writes and issues.
    wr0(0, 32'hFFFF_FFFF); ra1 = 5'd0; iss = 1'b1; iss_a = 5'd0;
    settle();
    chk("r0_fwd", rd1_a, 32'h0);
    clock_edge(); idle();
    settle();
    chk("r0_store", rd1_a,            32'h0);
    chk("r0_busy",  DW'(busy_any_a),  32'h0);
    clock_edge();

    // Scoreboard: issue, issue+write (set wins), then write alone clears.
    iss = 1'b1; iss_a = 5'd7; ra1 = 5'd7;
    settle();
    chk("iss_no_fwd", DW'(busy1_a), 32'h0);
    clock_edge(); idle();
    settle();
    chk("iss_set", DW'(busy1_a), 32'h1);
    clock_edge();
    wr0(7, 32'h77); iss = 1'b1; iss_a = 5'd7;
    settle(); clock_edge(); idle();
    settle();
    chk("iss_wins", DW'(busy1_a), 32'h1);
    clock_edge();
    wr0(7, 32'h78);
    settle();
    chk("clr_no_fwd", DW'(busy1_a), 32'h1);
    clock_edge(); idle();
    settle();
    chk("clr_done", DW'(busy1_a), 32'h0);
    clock_edge();

    // Reset beats a simultaneous write and a pending bit.
    wr0(3, 32'h0000_1234); iss = 1'b1; iss_a = 5'd3; ra1 = 5'd3;
    settle(); clock_edge(); idle();
    settle();
    chk("pre_rst_val",  rd1_a,           32'h0000_1234);
    chk("pre_rst_busy", DW'(busy_any_a), 32'h1);
    rst = 1'b1; wr1(3, 32'h0000_0099);
    settle();
    chk("rst_fwd", rd1_a, 32'h0000_0099);
    clock_edge(); idle();
    settle();
    chk("rst_val",  rd1_a,           32'h0);
    chk("rst_busy", DW'(busy_any_a), 32'h0);
    clock_edge();

    // Random traffic; small address window half the time to force collisions.
    for (int n = 0; n < 400; n++) begin
      int hi;
      hi    = ($urandom_range(0, 1) == 0) ? 7 : 31;
      rst   = ($urandom_range(0, 39) == 0);
      we0   = $urandom_range(0, 1);
      we1   = $urandom_range(0, 1);
      wa0   = AW'($urandom_range(0, hi));
      wa1   = AW'($urandom_range(0, hi));
      if ($urandom_range(0, 7) == 0) wa0 = AW'(IOREG);
      if ($urandom_range(0, 7) == 0) wa1 = AW'(IOREG);
      wd0   = $urandom;
      wd1   = $urandom;
      iodin = $urandom;
      iss   = $urandom_range(0, 1);
      iss_a = AW'($urandom_range(0, hi));
      ra1   = AW'($urandom_range(0, hi));
      ra2   = AW'($urandom_range(0, hi));
      settle();
      clock_edge();
    end

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter DW, 32, data width in bits (≥8).
REQ-002 Parameter AW, 5, address width; depth N = 2^AW registers.
REQ-003 Parameter IOREG, 30, index of the I/O-mapped register (1..N-1).
REQ-004 Parameter IOMODE, 1: 1 = writes to IOREG store iodin; 0 = IOREG is an ordinary register.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 ra1, ra2  in  AW each  read addresses.
REQ-008 rd1, rd2  out  DW each  read data (combinational).
REQ-009 we0, wa0, wd0  in  1/AW/DW  write port 0.
REQ-010 we1, wa1, wd1  in  1/AW/DW  write port 1 (higher priority).
REQ-011 iodin  in  DW  external data for the IOREG write.
REQ-012 ioout  out  DW  IOREG contents, forwarded.
REQ-013 iss, iss_a  in  1/AW  scoreboard issue: mark register iss_a pending.
REQ-014 busy1, busy2  out  1 each  pending flag of ra1/ra2 (combinational).
REQ-015 busy_any  out  1  OR of all pending flags.

Function
REQ-016 Register 0 SHALL read 0 always; writes and issues to address 0 are ignored, and busy for address 0 is 0.
REQ-017 Effective write: port p is effective when we_p=1 and wa_p≠0; if both are effective to the same address, port 1 SHALL win and port 0 is dropped.
REQ-018 Stored value: write data is wd_p, except address IOREG with IOMODE=1, where it is iodin.
REQ-019 Effective writes SHALL update the register at the next rising edge (1-cycle write latency).
REQ-020 Read forwarding: rdX SHALL equal the stored value of the highest-priority effective write whose address equals raX this cycle, else the register contents; raX=0 gives 0.
REQ-021 ioout SHALL equal the stored value of an effective write to IOREG this cycle, else register IOREG.
REQ-022 Scoreboard: a per-register pending bit SHALL be set at the edge after iss=1 (iss_a≠0) and cleared at the edge after an effective write to that address.
REQ-023 Simultaneous issue and write to the same address: set SHALL win (the bit ends at 1).
REQ-024 busyX SHALL reflect the current pending bit of raX without forwarding the same-cycle clear or set.
REQ-025 Two writes to distinct addresses in one cycle SHALL both commit and clear both pending bits.
REQ-026 Address arithmetic is unsigned AW-bit; no out-of-range addresses exist.

Reset
REQ-027 With rst=1 at a rising edge, all registers SHALL become 0 and all pending bits 0; writes and issues in that cycle are discarded.
REQ-028 rd1, rd2 and ioout SHALL keep forwarding effective writes while rst=1. After the edge they read 0, and busy1, busy2 and busy_any are 0.
REQ-029 rst SHALL take priority over every simultaneous write or issue, including reset asserted mid-sequence.
REQ-030 No power-on initial values SHALL be relied upon; state is defined only after the first reset.

Verification
REQ-031 Reset, write wd0=0x0000000B to r1 and wd1=0x00000011 to r2 in the same cycle; next cycle ra1=1, ra2=2 -> rd1=0x0B, rd2=0x11.
REQ-032 we0=we1=1, wa0=wa1=5, wd0=0xAAAA0000, wd1=0x5555FFFF with ra1=5 -> rd1=0x5555FFFF in the same cycle, and r5=0x5555FFFF afterwards.
REQ-033 IOMODE=1: write wa0=30, wd0=0x1, iodin=0xDEADBEEF -> ioout=0xDEADBEEF the same cycle and after; IOMODE=0 -> 0x1.
REQ-034 Write wa0=0, wd0=0xFFFFFFFF with ra1=0 -> rd1=0 in that cycle and later; iss with iss_a=0 -> busy_any stays 0.
REQ-035 iss with iss_a=7 -> next cycle busy1=1 for ra1=7. Same cycle: we0 to r7 and iss with iss_a=7 -> bit stays 1. Write only -> bit 0 next cycle.
REQ-036 With r3=0x1234 and r3 pending, rst=1 with we1 to r3 (wd1=0x99) -> next cycle rd1(ra1=3)=0 and busy_any=0.
